// File: rtl/lfsr_stream.sv
// Fibonacci LFSR that packs one emitted bit per enabled step into OUT_BITS-wide
// words delivered on a valid/ready stream. Zero-seed guard: LFSR_ZERO_GUARD_EN.
module lfsr_stream #(
  parameter int               WIDTH    = 16,
  parameter logic [WIDTH-1:0] TAPS     = WIDTH'(16'hB400),
  parameter logic [WIDTH-1:0] SEED     = WIDTH'(1),
  parameter int               OUT_BITS = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                en,
  input  logic                load,
  input  logic [WIDTH-1:0]    seed_in,
  output logic [OUT_BITS-1:0] out_data,
  output logic                out_valid,
  input  logic                out_ready,
  output logic                random_bit
`ifdef LFSR_ZERO_GUARD_EN
  ,
  output logic                lockup
`endif
);

  localparam int               CW       = (OUT_BITS > 1) ? $clog2(OUT_BITS) : 1;
  localparam logic [CW-1:0]    CNT_LAST = CW'(OUT_BITS - 1);

  logic [WIDTH-1:0]    sr_q, sr_d;
  // Only the first OUT_BITS-1 bits of a word need storing; the last bit is
  // taken straight from the register on the completing step.
  logic [OUT_BITS-2:0] acc_q, acc_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [OUT_BITS-1:0] out_data_q, out_data_d;
  logic                out_valid_q, out_valid_d;
  logic                random_bit_q, random_bit_d;
  logic                lockup_q, lockup_d;

  logic                last_bit;
  logic                step;
  logic                fb;
  logic                emit_bit;
  logic [OUT_BITS-1:0] word;
  logic [WIDTH-1:0]    seed_eff;

  assign last_bit = (cnt_q == CNT_LAST);
  assign step     = en && !(last_bit && out_valid_q && !out_ready);
  assign fb       = ^(sr_q & TAPS);
  assign emit_bit = sr_q[WIDTH-1];
  assign word     = {acc_q, emit_bit};

`ifdef LFSR_ZERO_GUARD_EN
  assign seed_eff = (seed_in == '0) ? SEED : seed_in;
`else
  assign seed_eff = seed_in;
`endif

  // NOTE: every always_comb output gets a hold/default value before any branch;
  // a path that leaves one unassigned would infer a latch.
  always_comb begin
    sr_d         = sr_q;
    acc_d        = acc_q;
    cnt_d        = cnt_q;
    out_data_d   = out_data_q;
    out_valid_d  = out_valid_q;
    random_bit_d = random_bit_q;
    lockup_d     = 1'b0;

    if (load) begin
      sr_d        = seed_eff;
      acc_d       = '0;
      cnt_d       = '0;
      out_valid_d = 1'b0;
      lockup_d    = (seed_in == '0);
    end else begin
      if (out_valid_q && out_ready) begin
        out_valid_d = 1'b0;
      end
      if (step) begin
        sr_d         = {sr_q[WIDTH-2:0], fb};
        acc_d        = word[OUT_BITS-2:0];
        random_bit_d = emit_bit;
        cnt_d        = last_bit ? '0 : cnt_q + CW'(1);
        // A completing step may coincide with a consume: valid stays high.
        if (last_bit) begin
          out_data_d  = word;
          out_valid_d = 1'b1;
        end
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge value of its inputs regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr_q         <= SEED;
      acc_q        <= '0;
      cnt_q        <= '0;
      out_data_q   <= '0;
      out_valid_q  <= 1'b0;
      random_bit_q <= 1'b0;
      lockup_q     <= 1'b0;
    end else begin
      sr_q         <= sr_d;
      acc_q        <= acc_d;
      cnt_q        <= cnt_d;
      out_data_q   <= out_data_d;
      out_valid_q  <= out_valid_d;
      random_bit_q <= random_bit_d;
      lockup_q     <= lockup_d;
    end
  end

  assign out_data   = out_data_q;
  assign out_valid  = out_valid_q;
  assign random_bit = random_bit_q;

`ifdef LFSR_ZERO_GUARD_EN
  assign lockup = lockup_q;
`else
  // Without the guard the pulse has no consumer.
  logic unused_lockup;
  assign unused_lockup = lockup_q;
`endif

endmodule

// File: tb/tb_lfsr_stream.sv
// Directed bench for lfsr_stream: a 5-bit instance against hand-derived vectors
// and a default-parameter instance against a software LFSR model.
module tb_lfsr_stream;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  // Small instance: WIDTH=5, TAPS=5'h1B, SEED=1, OUT_BITS=8.
  logic       s_en, s_load, s_ready;
  logic [4:0] s_seed;
  logic [7:0] s_data;
  logic       s_valid, s_rbit;
  // Default instance.
  logic        b_en, b_load, b_ready;
  logic [15:0] b_seed;
  logic [7:0]  b_data;
  logic        b_valid, b_rbit;
`ifdef LFSR_ZERO_GUARD_EN
  logic s_lockup, b_lockup;
`endif

  lfsr_stream #(.WIDTH(5), .TAPS(5'h1B), .SEED(5'd1), .OUT_BITS(8)) u_small (
    .clk(clk), .rst_n(rst_n), .en(s_en), .load(s_load), .seed_in(s_seed),
    .out_data(s_data), .out_valid(s_valid), .out_ready(s_ready),
    .random_bit(s_rbit)
`ifdef LFSR_ZERO_GUARD_EN
    , .lockup(s_lockup)
`endif
  );

  lfsr_stream u_big (
    .clk(clk), .rst_n(rst_n), .en(b_en), .load(b_load), .seed_in(b_seed),
    .out_data(b_data), .out_valid(b_valid), .out_ready(b_ready),
    .random_bit(b_rbit)
`ifdef LFSR_ZERO_GUARD_EN
    , .lockup(b_lockup)
`endif
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Software LFSR: collects eight emitted bits, MSB first.
  task automatic model_word(input int w, input logic [31:0] taps, input logic [31:0] st_in,
                            output logic [31:0] st_out, output logic [31:0] word);
    logic [31:0] st, mask;
    st   = st_in;
    mask = (32'd1 << w) - 32'd1;
    word = '0;
    for (int i = 0; i < 8; i++) begin
      word = {word[30:0], st[w-1]};
      st   = ((st << 1) | {31'd0, ^(st & taps)}) & mask;
    end
    st_out = st;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0]  word1;
    logic [31:0] ms, mw, bst, bw;
    int          cycle, consumed;
    logic        prev_valid, prev_ready;
    logic [7:0]  prev_data;

    word1  = 8'h0D;  // bits 0,0,0,0,1,1,0,1 from seed 5'b00001
    rst_n  = 1'b0;
    s_en   = 1'b1; s_load = 1'b0; s_ready = 1'b1; s_seed = 5'd0;
    b_en   = 1'b0; b_load = 1'b0; b_ready = 1'b0; b_seed = 16'd0;
    #12;

    // Reset values.
    check("rst_valid", s_valid, 0);
    check("rst_data", s_data, 0);
    check("rst_rbit", s_rbit, 0);
    check("rst_big_valid", b_valid, 0);
`ifdef LFSR_ZERO_GUARD_EN
    check("rst_lockup", s_lockup, 0);
`endif
    rst_n = 1'b1;

    // First word: bit stream and latency.
    for (int i = 0; i < 8; i++) begin
      tick();
      check($sformatf("bit%0d", i), s_rbit, word1[7-i]);
      if (i == 6) check("latency_not_yet", s_valid, 0);
    end
    check("first_valid", s_valid, 1);
    check("first_data", s_data, 8'h0D);
    check("sr_after_8", u_small.sr_q, 5'b01001);

    // Stall: pending word held, bits for next word gathered up to the last.
    s_ready = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      check("stall_valid", s_valid, 1);
      check("stall_data", s_data, 8'h0D);
    end
    check("stall_cnt", u_small.cnt_q, 7);
    check("stall_sr", u_small.sr_q, 5'b01011);
    model_word(5, 32'h1B, 32'd1, ms, mw);
    model_word(5, 32'h1B, ms, ms, mw);
    s_ready = 1'b1;
    tick();
    check("release_valid", s_valid, 1);
    check("release_data", s_data, mw);

    // Load seed 1, then step every other cycle.
    s_en = 1'b0; s_load = 1'b1; s_seed = 5'd1;
    tick();
    s_load = 1'b0;
    check("load_valid_drop", s_valid, 0);
    for (int k = 0; k < 15; k++) begin
      s_en = (k % 2 == 0);
      tick();
      check($sformatf("toggle_bit%0d", k), s_rbit, word1[7-k/2]);
      if (k == 13) check("toggle_not_yet", s_valid, 0);
    end
    check("toggle_valid", s_valid, 1);
    check("toggle_data", s_data, 8'h0D);

    // Load mid-word while a word is pending.
    s_ready = 1'b0; s_en = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    check("pending_valid", s_valid, 1);
    s_load = 1'b1; s_seed = 5'b00001;
    tick();
    s_load = 1'b0; s_ready = 1'b1;
    check("midload_valid", s_valid, 0);
    check("midload_data_hold", s_data, 8'h0D);
    check("midload_rbit_hold", s_rbit, 0);
    for (int i = 0; i < 8; i++) begin
      tick();
      if (i == 6) check("midload_not_yet", s_valid, 0);
    end
    check("midload_valid_again", s_valid, 1);
    check("midload_data_again", s_data, 8'h0D);

    // Zero seed load.
    s_load = 1'b1; s_seed = 5'd0;
    tick();
    s_load = 1'b0;
`ifdef LFSR_ZERO_GUARD_EN
    check("lockup_pulse", s_lockup, 1);
    tick();
    check("lockup_clear", s_lockup, 0);
    for (int i = 0; i < 7; i++) tick();
    check("guard_valid", s_valid, 1);
    check("guard_data", s_data, 8'h0D);
`else
    for (int i = 0; i < 8; i++) tick();
    check("zero_valid", s_valid, 1);
    check("zero_data", s_data, 8'h00);
    for (int i = 0; i < 8; i++) tick();
    check("zero_valid2", s_valid, 1);
    check("zero_data2", s_data, 8'h00);
    check("zero_rbit", s_rbit, 0);
`endif

    // Default instance: 4096 consumed words against the model, ready gapped.
    s_en = 1'b0;
    b_en = 1'b1;
    bst = 32'd1; cycle = 0; consumed = 0;
    prev_valid = 1'b0; prev_ready = 1'b0; prev_data = '0;
    while (consumed < 4096 && cycle < 60000) begin
      if (prev_valid && !prev_ready) begin
        check("big_hold_valid", b_valid, 1);
        check("big_hold_data", b_data, prev_data);
      end
      if (cycle == 7) check("big_latency_early", b_valid, 0);
      if (cycle == 8) check("big_latency", b_valid, 1);
      b_ready = (cycle % 4 != 3);
      if (b_valid && b_ready) begin
        model_word(16, 32'hB400, bst, bst, bw);
        check($sformatf("big_word%0d", consumed), b_data, bw);
        consumed++;
      end
      prev_valid = b_valid; prev_ready = b_ready; prev_data = b_data;
      tick();
      cycle++;
    end
    check("big_count", consumed, 4096);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/lfsr_stream.md
Name: lfsr_stream

Overview:
- Parametrised Fibonacci LFSR pseudo-random generator.
- Steps one bit per enabled clock and packs bits into OUT_BITS-wide words.
- Delivers words on a valid/ready stream interface, with run-time seed reload.
- Successor to the fixed 5-bit single-bit generator; feeds display noise, dithering and test-pattern consumers.

Parameters:
- WIDTH, 16, LFSR state width (>= 3).
- TAPS, 16'hB400, tap mask. Bit i set means sr[i] is XORed into feedback.
- SEED, 1, state value after reset (must be non-zero).
- OUT_BITS, 8, bits per output word (2..32).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- en  in  1  step enable.
- load  in  1  single-cycle seed load strobe.
- seed_in  in  WIDTH  seed value, sampled when load=1.
- out_data  out  OUT_BITS  completed random word.
- out_valid  out  1  out_data holds an unconsumed word.
- out_ready  in  1  consumer accepts the word.
- random_bit  out  1  registered bit emitted by the most recent step.
- lockup  out  1  zero-state guard pulse (present only with LFSR_ZERO_GUARD_EN).

Behaviour:
- Reset (async assert, sync release):
  - sr=SEED, acc=0, cnt=0.
  - out_data=0, out_valid=0, random_bit=0, lockup=0.
- Step definition:
  - fb = XOR-reduce(sr & TAPS).
  - sr <= {sr[WIDTH-2:0], fb}.
  - The emitted bit b is the pre-step sr[WIDTH-1]; random_bit <= b.
- Word assembly:
  - Each step does acc <= {acc[OUT_BITS-2:0], b}; the first emitted bit lands in the word MSB.
  - cnt counts 0..OUT_BITS-1 and wraps to 0 on the last bit.
- Completion: on the step with cnt==OUT_BITS-1, out_data <= the completed word and out_valid <= 1 in the next cycle.
- Stall: step = en && !(cnt==OUT_BITS-1 && out_valid && !out_ready).
  - Bits for the next word are still gathered while a word is pending.
  - Only the final bit waits. Nothing is lost or duplicated.
- Handshake:
  - out_valid && out_ready consumes the word.
  - out_valid falls next cycle unless a new word completes in the same cycle, in which case it stays 1 with new data.
  - out_data is stable while out_valid && !out_ready.
  - Sustained throughput is 1 word per OUT_BITS enabled cycles.
- en=0: sr, acc, cnt and random_bit hold. A pending handshake still completes.
- Load (priority over step and handshake):
  - sr <= seed_in; acc, cnt cleared; out_valid <= 0 (pending word discarded).
  - out_data and random_bit hold.
  - No step occurs in the load cycle.
- Latency:
  - First out_valid arrives OUT_BITS+1 cycles after reset release or load, with en held high.
  - Rule: OUT_BITS step cycles, then valid the following cycle.
- All-zero state: never produced by stepping from non-zero. Reachable only via load of 0; see optional feature.
- Reset mid-stream: any partial word and pending word are dropped immediately.

Optional Feature:
- Macro LFSR_ZERO_GUARD_EN.
- Defined:
  - A load with seed_in==0 loads SEED instead.
  - lockup pulses 1 for exactly one cycle, the cycle after the load.
  - Port lockup exists.
- Undefined:
  - seed_in==0 is loaded verbatim and the generator emits all-zero words indefinitely.
  - No lockup port.

Test Plan:
- Reset with WIDTH=5, TAPS=5'h1B, SEED=1, OUT_BITS=8, en=1, out_ready=1.
  - Expect out_valid first at cycle 9 with out_data=8'h0D.
  - Bit stream 0,0,0,0,1,1,0,1.
  - sr=5'b01001 after 8 steps.
- Same configuration, out_ready=0 for 20 cycles.
  - out_valid=1 with out_data=8'h0D held stable.
  - Stepping stops with cnt=7.
  - After out_ready rises, the next word follows 1 cycle later with no lost bits (compare against a reference model).
- en toggled 1/0 every cycle: word 8'h0D still produced, taking 16 cycles; random_bit holds during en=0.
- load with seed_in=5'b00001 mid-word, while a word is pending:
  - out_valid drops the next cycle.
  - The sequence restarts and yields 8'h0D again 9 cycles after load.
- LFSR_ZERO_GUARD_EN defined, load seed_in=0: lockup high for 1 cycle, then the output matches the SEED=1 stream (8'h0D).
  - Undefined: output words are 8'h00 forever.
- Default parameters (WIDTH=16, TAPS=16'hB400): 4096 consumed words match a bit-exact software model.
  - out_valid never asserts without a preceding completed word.
